s1_cfg_loader: RTL and testbench
================================

Name: s1_cfg_loader

Overview:
- Serial configuration loader sitting directly upstream of an array of s1 logic cells.
- Receives a framed serial bitstream and assembles one 4-bit truth table {D11,D10,D01,D00} per cell.
- Checks even parity over the frame and drives the constant data inputs of NCELLS s1 instances in parallel.
- Last good configuration is held stable while a new frame loads; it is replaced only after a frame passes its parity check.

Parameters:
- NCELLS, 8, number of downstream s1 cells configured.
- SYNC, 4'b1010, frame sync pattern; first received bit is the MSB.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset; clr=0 clears all state immediately.
- start  input  1  one-cycle request to load a new frame.
- abort  input  1  synchronous cancel of a load in progress.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only on cycles where this is 1.
- cfg_out  output  4*NCELLS  configuration; cell k uses bits [4k+3:4k] = {D11,D10,D01,D00}.
- cfg_valid  output  1  at least one frame has loaded successfully since reset.
- busy  output  1  a load is in progress (FSM state is not IDLE).
- done  output  1  one-cycle pulse on successful load.
- err  output  1  parity failure on the last frame; sticky.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; cfg_out=0, cfg_valid=0, busy=0, done=0, err=0; shadow register, bit counter and sync shift register all 0.
- FSM states: IDLE, SYNC, DATA, PAR, CHECK.
- IDLE:
  - start=1 -> SYNC; clear err, the sync shift register and the bit counter.
  - start has no effect in any other state.
- SYNC:
  - On each sin_valid, shift sin into a 4-bit register (new bit enters at the LSB).
  - When the register value after the shift equals SYNC -> DATA.
  - Overlapping search is allowed: stream 1,1,0,1,0 matches on the 5th bit.
- DATA:
  - On each sin_valid, write sin into shadow[cnt] and increment cnt.
  - The first data bit goes to shadow[0] (LSB-first).
  - After bit 4*NCELLS-1 is sampled -> PAR.
  - Counter width is clog2(4*NCELLS+1); it never wraps within a frame.
- PAR:
  - On sin_valid, sample the parity bit -> CHECK.
  - Even parity is required: XOR of all data bits XOR the parity bit must equal 0.
- CHECK (exactly one cycle, then -> IDLE):
  - Parity OK: cfg_out<=shadow, cfg_valid<=1, done=1 for this one cycle.
  - Parity bad: err<=1; cfg_out and cfg_valid unchanged; done stays 0.
- Latency: done/err and the new cfg_out become visible in the cycle after the parity bit is sampled.
- sin_valid=0 cycles stall the FSM in any receive state; there is no timeout.
- abort=1 in SYNC/DATA/PAR:
  - -> IDLE next cycle; shadow is discarded; cfg_out, cfg_valid and err are unchanged; no done.
  - abort in IDLE or CHECK is ignored; CHECK always completes.
- Simultaneous abort and sin_valid: abort wins and the bit is not consumed.
- busy = (state != IDLE), decoded from registered state.
- cfg_out changes only in CHECK or on reset, so downstream s1 cells never see a partially loaded configuration.
- clr asserted mid-frame: all state returns to reset values, including cfg_out=0 and cfg_valid=0.

Test Plan (NCELLS=2, so the frame carries 8 data bits):
- Reset, start, stream 1,0,1,0 then data 0,1,0,1,1,0,1,0 (0x5A LSB-first) then parity 0 -> cfg_out=8'h5A, done high for 1 cycle, cfg_valid=1, err=0, busy=0 afterwards.
- After the 0x5A load, send frame 0xFF with parity 1 -> err=1, done=0, cfg_out stays 8'h5A, cfg_valid=1; the next start clears err.
- Preamble 0,1,1,0,1,0 before the 0xA5 frame (LSB-first 1,0,1,0,0,1,0,1) with parity 0 -> sync detected on the 6th bit, cfg_out=8'hA5.
- 0x3C frame with sin_valid low every other cycle and randomly for up to 5 cycles -> cfg_out=8'h3C; done comes exactly 1 cycle after the valid parity bit.
- abort after the 3rd data bit of frame 0x0F, with 0x5A previously loaded -> busy drops next cycle, cfg_out=8'h5A, err=0; start pulses during DATA are ignored.
- clr low for 1 cycle after the 5th data bit, with 0x5A previously loaded -> cfg_out=0, cfg_valid=0, state IDLE; a fresh 0x5A frame then loads normally.

Source files
------------

// File: rtl/s1_cfg_loader.sv
// Serial configuration loader for an array of s1 logic cells: finds a sync word,
// assembles 4*NCELLS truth-table bits LSB-first, and commits them only on good even parity.
module s1_cfg_loader #(
  parameter int          NCELLS = 8,
  parameter logic [3:0]  SYNC   = 4'b1010
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sin,
  input  logic                  sin_valid,
  output logic [4*NCELLS-1:0]   cfg_out,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NBITS = 4 * NCELLS;
  localparam int CW    = $clog2(NBITS + 1);
  localparam int IW    = $clog2(NBITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PAR,
    ST_CHECK
  } state_t;

  state_t           state;
  logic [3:0]       sync_sr;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] shadow;
  logic [3:0]       sync_next;

  assign sync_next = {sync_sr[2:0], sin};
  assign busy      = (state != ST_IDLE);

  // The commit happens on the edge that samples the parity bit, so cfg_out and
  // done are already valid while the FSM sits in CHECK for its single cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of state, cnt and shadow.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      sync_sr   <= '0;
      cnt       <= '0;
      shadow    <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SYNC;
            err     <= 1'b0;
            sync_sr <= '0;
            cnt     <= '0;
          end
        end

        ST_SYNC: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (sin_valid) begin
            sync_sr <= sync_next;
            if (sync_next == SYNC) state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (sin_valid) begin
            shadow[cnt[IW-1:0]] <= sin;
            cnt                 <= cnt + CW'(1);
            if (cnt == CW'(NBITS - 1)) state <= ST_PAR;
          end
        end

        ST_PAR: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (sin_valid) begin
            state <= ST_CHECK;
            if ((^shadow ^ sin) == 1'b0) begin
              cfg_out   <= shadow;
              cfg_valid <= 1'b1;
              done      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_CHECK: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s1_cfg_loader.sv
// Directed bench for s1_cfg_loader with NCELLS=2 (8 data bits per frame).
module tb_s1_cfg_loader;

  logic       clk;
  logic       clr;
  logic       start;
  logic       abort;
  logic       sin;
  logic       sin_valid;
  logic [7:0] cfg_out;
  logic       cfg_valid;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  s1_cfg_loader #(.NCELLS(2), .SYNC(4'b1010)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .sin       (sin),
    .sin_valid (sin_valid),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic test_reset();
    checks++;
    if (cfg_out !== 8'h00 || cfg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: cfg_out=%h cfg_valid=%b busy=%b done=%b err=%b, required 00 0 0 0 0",
               cfg_out, cfg_valid, busy, done, err);
    end
  endtask

  task automatic load_and_check(input string name, input logic [7:0] d, input logic par);
    pulse_start();
    send_sync();
    send_data(d);
    send_bit(par);
    checks++;
    if (cfg_out !== d || done !== 1'b1 || cfg_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s commit: cfg_out=%h done=%b cfg_valid=%b err=%b, required %h 1 1 0",
               name, cfg_out, done, cfg_valid, err, d);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_out !== d) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b cfg_out=%h, required 0 0 %h",
               name, done, busy, cfg_out, d);
    end
  endtask

  task automatic test_load_5a();
    load_and_check("load_5a", 8'h5A, 1'b0);
  endtask

  task automatic test_parity_error();
    pulse_start();
    send_sync();
    send_data(8'hFF);
    send_bit(1'b1);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cfg_out !== 8'h5A || cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL parity_err: err=%b done=%b cfg_out=%h cfg_valid=%b, required 1 0 5a 1",
               err, done, cfg_out, cfg_valid);
    end
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_err_sticky: err=%b busy=%b, required 1 0", err, busy);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clears_err: err=%b busy=%b, required 0 1", err, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_out !== 8'h5A) begin
      errors++;
      $display("FAIL abort_in_sync: busy=%b cfg_out=%h, required 0 5a", busy, cfg_out);
    end
  endtask

  task automatic test_preamble();
    logic [5:0] pre;
    pre = 6'b011010;
    pulse_start();
    for (int i = 5; i >= 0; i--) send_bit(pre[i]);
    send_data(8'hA5);
    send_bit(1'b0);
    checks++;
    if (cfg_out !== 8'hA5 || done !== 1'b1) begin
      errors++;
      $display("FAIL preamble: cfg_out=%h done=%b, required a5 1", cfg_out, done);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [3:0] sp;
    logic [7:0] d;
    logic       b;
    int         idle;
    sp = 4'b1010;
    d  = 8'h3C;
    pulse_start();
    for (int i = 0; i < 13; i++) begin
      if (i < 4)       b = sp[3-i];
      else if (i < 12) b = d[i-4];
      else             b = 1'b0;
      if (i == 12) begin
        checks++;
        if (done !== 1'b0 || cfg_out !== 8'hA5 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_pre_par: done=%b cfg_out=%h busy=%b, required 0 a5 1",
                   done, cfg_out, busy);
        end
      end
      send_bit(b);
      if (i < 12) begin
        idle = (i % 2 == 0) ? 1 : int'($urandom_range(1, 5));
        for (int k = 0; k < idle; k++) tick();
      end
    end
    checks++;
    if (cfg_out !== 8'h3C || done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL stall_commit: cfg_out=%h done=%b err=%b, required 3c 1 0", cfg_out, done, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_after: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    load_and_check("reload_5a", 8'h5A, 1'b0);
    pulse_start();
    send_sync();
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_data: busy=%b, required 1", busy);
    end
    send_bit(1'b1);
    abort     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    tick();
    abort     = 1'b0;
    sin_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_out !== 8'h5A || err !== 1'b0 || done !== 1'b0 || cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort: busy=%b cfg_out=%h err=%b done=%b cfg_valid=%b, required 0 5a 0 0 1",
               busy, cfg_out, err, done, cfg_valid);
    end
  endtask

  task automatic test_clr_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    pulse_start();
    send_sync();
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    clr = 1'b0;
    #1;
    checks++;
    if (cfg_out !== 8'h00 || cfg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_async: cfg_out=%h cfg_valid=%b busy=%b done=%b err=%b, required 00 0 0 0 0",
               cfg_out, cfg_valid, busy, done, err);
    end
    tick();
    clr = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_release: busy=%b cfg_valid=%b, required 0 0", busy, cfg_valid);
    end
    load_and_check("fresh_5a", 8'h5A, 1'b0);
  endtask

  initial begin
    clr       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    clr = 1'b1;
    tick();
    test_load_5a();
    test_parity_error();
    test_preamble();
    test_stall();
    test_abort();
    test_clr_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
